// File: rtl/aes_sd_stream_ctrl.sv
// Block-level stream wrapper around a word-serial AES core: power-up start, text load, result unload, hold.
// Optional WAIT_DONE watchdog enabled by defining AES_SD_CTRL_TIMEOUT_EN.
module aes_sd_stream_ctrl #(
    parameter int unsigned INIT_WAIT = 86,
    parameter logic [7:0]  DONE_CODE = 8'h10,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_text,
    input  logic [127:0] in_key,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_text,
    output logic         out_error,
    output logic         core_start,
    output logic [31:0]  core_data_in,
    output logic [127:0] core_key_in,
    output logic         core_sel_enc_dec,
    input  logic [31:0]  core_data_out,
    input  logic [7:0]   core_signals
);

    typedef enum logic [2:0] {
        S_INIT_START, S_INIT_WAIT, S_IDLE, S_START,
        S_LOAD, S_WAIT_DONE, S_UNLOAD, S_HOLD
    } state_t;

    localparam logic [6:0] INIT_LAST = 7'(INIT_WAIT - 1);

    state_t       state, state_next;
    logic [6:0]   cnt, cnt_next;
    logic [127:0] text_reg;
    logic [127:0] key_reg;
    logic         mode_reg;
    logic         accept, capture, timeout_hit;
    logic [1:0]   cap_idx;

    function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [1:0] idx);
        case (idx)
            2'd0:    word_of = blk[127:96];
            2'd1:    word_of = blk[95:64];
            2'd2:    word_of = blk[63:32];
            default: word_of = blk[31:0];
        endcase
    endfunction

`ifdef AES_SD_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] timer;
    logic          error_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                   timer <= '0;
        else if (state != S_WAIT_DONE) timer <= '0;
        else                          timer <= timer + 1'b1;
    end

    assign timeout_hit = (state == S_WAIT_DONE) && (core_signals != DONE_CODE) &&
                         (timer == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      error_reg <= 1'b0;
        else if (timeout_hit)            error_reg <= 1'b1;
        else if (out_valid && out_ready) error_reg <= 1'b0;
    end

    assign out_error = error_reg;
`else
    assign timeout_hit = 1'b0;
    assign out_error   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_INIT_START;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        in_ready     = 1'b0;
        core_start   = 1'b0;
        core_data_in = 32'h0;
        accept       = 1'b0;
        capture      = 1'b0;
        cap_idx      = 2'd0;
        case (state)
            S_INIT_START: begin
                core_start = 1'b1;
                if (cnt == 7'd1) begin
                    state_next = S_INIT_WAIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 7'd1;
                end
            end
            S_INIT_WAIT: begin
                if (cnt == INIT_LAST) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 7'd1;
                end
            end
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = S_START;
                    cnt_next   = '0;
                end
            end
            S_START: begin
                core_start = 1'b1;
                if (cnt == 7'd1) begin
                    state_next = S_LOAD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 7'd1;
                end
            end
            S_LOAD: begin
                core_data_in = word_of(text_reg, cnt[1:0]);
                if (cnt == 7'd3) begin
                    state_next = S_WAIT_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 7'd1;
                end
            end
            S_WAIT_DONE: begin
                // The done cycle itself carries the first result word.
                if (core_signals == DONE_CODE) begin
                    capture    = 1'b1;
                    state_next = S_UNLOAD;
                    cnt_next   = 7'd1;
                end else if (timeout_hit) begin
                    state_next = S_HOLD;
                    cnt_next   = '0;
                end
            end
            S_UNLOAD: begin
                capture = 1'b1;
                cap_idx = cnt[1:0];
                if (cnt == 7'd3) begin
                    state_next = S_HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 7'd1;
                end
            end
            S_HOLD: begin
                if (out_ready) state_next = S_IDLE;
            end
            default: begin
                state_next = S_INIT_START;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            text_reg <= '0;
            key_reg  <= '0;
            mode_reg <= 1'b1;
            out_text <= '0;
        end else begin
            if (accept) begin
                text_reg <= in_text;
                key_reg  <= in_key;
                mode_reg <= in_mode;
            end
            if (capture) begin
                case (cap_idx)
                    2'd0:    out_text[127:96] <= core_data_out;
                    2'd1:    out_text[95:64]  <= core_data_out;
                    2'd2:    out_text[63:32]  <= core_data_out;
                    default: out_text[31:0]   <= core_data_out;
                endcase
            end else if (timeout_hit) begin
                out_text <= '0;
            end
        end
    end

    assign out_valid        = (state == S_HOLD);
    assign core_key_in      = key_reg;
    assign core_sel_enc_dec = mode_reg;

endmodule

// File: tb/tb_aes_sd_stream_ctrl.sv
// Self-checking bench for aes_sd_stream_ctrl: vector table, scoreboard of result blocks, init/reset/timeout sequences.
module tb_aes_sd_stream_ctrl;

    localparam logic [7:0] DONE = 8'h10;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_text = '0;
    logic [127:0] in_key = '0;
    logic         in_mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_text;
    logic         out_error;
    logic         core_start;
    logic [31:0]  core_data_in;
    logic [127:0] core_key_in;
    logic         core_sel_enc_dec;
    logic [31:0]  core_data_out = '0;
    logic [7:0]   core_signals = '0;

    always #5 clk = ~clk;

    aes_sd_stream_ctrl dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_text(in_text), .in_key(in_key), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text), .out_error(out_error),
        .core_start(core_start), .core_data_in(core_data_in), .core_key_in(core_key_in),
        .core_sel_enc_dec(core_sel_enc_dec), .core_data_out(core_data_out), .core_signals(core_signals)
    );

    typedef struct {
        logic [127:0] text;
        logic [127:0] key;
        logic         mode;
        logic [31:0]  a, b, c, d;
        int           delay;
        int           hold;
    } vec_t;

    vec_t         vecs[4];
    logic [127:0] exp_q[$];
    int           n_cmp = 0;
    int           n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] nondone();
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        if (v == DONE) v = 8'h11;
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_in_ready"}, in_ready, 1'b0);
        chk1({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_text"}, out_text, '0);
        chk1({tag, "_out_error"}, out_error, 1'b0);
        chk1({tag, "_core_start"}, core_start, 1'b1);
        chk({tag, "_core_data_in"}, {96'h0, core_data_in}, '0);
        chk({tag, "_core_key_in"}, core_key_in, '0);
        chk1({tag, "_sel_enc_dec"}, core_sel_enc_dec, 1'b1);
    endtask

    // Releases reset and measures the start pulse and the idle gap before in_ready.
    task automatic init_seq();
        int fall_i = -1;
        int rise_i = -1;
        int glitch = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        chk1("init_start_c0", core_start, 1'b1);
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
            if (fall_i < 0 && !core_start) fall_i = i;
            else if (fall_i >= 0 && core_start) glitch++;
            if (in_ready) begin
                rise_i = i;
                break;
            end
        end
        chki("init_start_len", fall_i, 1);
        chki("init_wait_len", rise_i - fall_i, 86);
        chki("init_wait_glitch", glitch, 0);
    endtask

    task automatic accept_block(input vec_t v);
        for (int i = 0; i < 200 && !in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        chk1("accept_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_text  = v.text;
        in_key   = v.key;
        in_mode  = v.mode;
        @(posedge clk);
        #1 in_valid = 1'b0;
        exp_q.push_back({v.a, v.b, v.c, v.d});
    endtask

    task automatic check_start_load(input vec_t v);
        logic [127:0] t;
        t = v.text;
        chk1("start0_core_start", core_start, 1'b1);
        chk1("start0_in_ready", in_ready, 1'b0);
        chk("start0_key", core_key_in, v.key);
        chk1("start0_mode", core_sel_enc_dec, v.mode);
        chk("start0_data_in", {96'h0, core_data_in}, '0);
        @(posedge clk);
        #1 chk1("start1_core_start", core_start, 1'b1);
        for (int w = 0; w < 4; w++) begin
            @(posedge clk);
            #1;
            chk1("load_core_start", core_start, 1'b0);
            chk("load_word", {96'h0, core_data_in}, {96'h0, t[127-32*w -: 32]});
        end
        @(posedge clk);
        #1 chk("after_load_data_in", {96'h0, core_data_in}, '0);
    endtask

    task automatic deliver(input vec_t v);
        logic [127:0] exp;
        for (int d = 0; d < v.delay; d++) begin
            core_signals = nondone();
            in_valid = 1'b1;
            in_text  = ~v.text;
            in_key   = ~v.key;
            in_mode  = ~v.mode;
            chk1("busy_in_ready", in_ready, 1'b0);
            chk1("busy_out_valid", out_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        core_signals = DONE;
        core_data_out = v.a;
        @(posedge clk);
        #1 core_signals = nondone();
        core_data_out = v.b;
        chk1("unload_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1 core_data_out = v.c;
        @(posedge clk);
        #1 core_data_out = v.d;
        chk1("unload_last_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1 core_signals = 8'h00;
        chk1("hold_out_valid", out_valid, 1'b1);
        chk1("hold_out_error", out_error, 1'b0);
        chk("hold_key_kept", core_key_in, v.key);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_empty_on_result: actual=0 entries required>=1");
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        chk("hold_out_text", out_text, exp);
        out_ready = 1'b0;
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk);
            #1;
            chk1("stall_out_valid", out_valid, 1'b1);
            chk("stall_out_text", out_text, exp);
            chk1("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk1("consumed_out_valid", out_valid, 1'b0);
        chk1("consumed_in_ready", in_ready, 1'b1);
    endtask

    task automatic run_block(input vec_t v);
        accept_block(v);
        check_start_load(v);
        deliver(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t lv;
        vecs[0] = '{128'h00112233_44556677_8899aabb_ccddeeff, 128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b1,
                    32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a, 2, 10};
        vecs[1] = '{{128{1'b1}}, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 1'b0,
                    32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32, 0, 0};
        vecs[2] = '{128'h0, {128{1'b1}}, 1'b1,
                    32'hdeadbeef, 32'hcafef00d, 32'h12345678, 32'h9abcdef0, 5, 1};
        vecs[3] = '{128'h80000000_00000001_a5a5a5a5_5a5a5a5a, 128'hfedcba98_76543210_01234567_89abcdef, 1'b0,
                    32'h00000001, 32'h80000000, 32'hffffffff, 32'h00000000, 1, 3};

        #12 check_reset_outputs("por");
        init_seq();

        for (int i = 0; i < 4; i++) run_block(vecs[i]);

`ifdef AES_SD_CTRL_TIMEOUT_EN
        begin
            int hit = -1;
            accept_block(vecs[2]);
            check_start_load(vecs[2]);
            for (int j = 1; j <= 300; j++) begin
                core_signals = nondone();
                @(posedge clk);
                #1;
                if (out_valid) begin
                    hit = j;
                    break;
                end
            end
            core_signals = 8'h00;
            chki("timeout_cycles", hit, 255);
            chk1("timeout_out_error", out_error, 1'b1);
            chk("timeout_out_text", out_text, '0);
            void'(exp_q.pop_front());
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            chk1("timeout_error_cleared", out_error, 1'b0);
            chk1("timeout_consumed", out_valid, 1'b0);
        end
`else
        lv = vecs[3];
        lv.delay = 300;
        lv.hold = 2;
        run_block(lv);
`endif

        accept_block(vecs[0]);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 chk("midreset_word2", {96'h0, core_data_in}, {96'h0, 32'h44556677});
        #2 reset = 1'b0;
        #1 check_reset_outputs("midreset");
        void'(exp_q.pop_back());
        @(posedge clk);
        #1 check_reset_outputs("midreset_held");
        init_seq();
        run_block(vecs[1]);

        chki("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_sd_stream_ctrl.md
AES_SD_STREAM_CTRL -- requirements
Module: aes_sd_stream_ctrl

Interface
REQ-001 Parameters SHALL be: INIT_WAIT, 86, idle cycles after the power-up start pulse; DONE_CODE, 8'h10, core_signals value marking the first valid output word; TIMEOUT, 255, maximum WAIT_DONE cycles when the watchdog is compiled in.
REQ-002 The design SHALL use one clock and an asynchronous, active-low reset, with ports `clk` and `reset`.
REQ-003 Ports SHALL be:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: block offered.
- `in_ready` out 1: block accepted when high together with `in_valid`.
- `in_text` in 128: plaintext or ciphertext; bits 127:96 are sent first.
- `in_key` in 128: cipher key.
- `in_mode` in 1: 1 = decrypt, 0 = encrypt.
- `out_valid` out 1: result held.
- `out_ready` in 1: result consumed.
- `out_text` out 128: result block.
- `out_error` out 1: watchdog abort flag.
- `core_start` out 1, `core_data_in` out 32, `core_key_in` out 128, `core_sel_enc_dec` out 1: drive the AES word-serial core.
- `core_data_out` in 32, `core_signals` in 8: read from the AES word-serial core.

Function
REQ-004 States SHALL be INIT_START, INIT_WAIT, IDLE, START, LOAD, WAIT_DONE, UNLOAD and HOLD; a 7-bit cycle counter SHALL serve INIT_WAIT, START and LOAD/UNLOAD.
REQ-005 INIT_START SHALL assert `core_start` for 2 cycles, then go to INIT_WAIT.
REQ-006 INIT_WAIT SHALL hold `core_start`=0 for INIT_WAIT cycles, then go to IDLE.
REQ-007 In IDLE, `in_ready`=1 and `in_ready` SHALL be 0 in every other state.
- On `in_valid`&&`in_ready`, latch `in_text`, `in_key` and `in_mode`, then go to START next cycle.
REQ-008 `core_key_in` and `core_sel_enc_dec` SHALL drive the latched key and mode from acceptance until the block leaves UNLOAD.
REQ-009 START SHALL assert `core_start` for exactly 2 cycles, with `core_data_in`=0.
REQ-010 LOAD SHALL drive latched text words 127:96, 95:64, 63:32 and 31:0 on `core_data_in` in 4 consecutive cycles, with `core_start`=0.
- The first word SHALL appear in the cycle immediately after START ends.
REQ-011 Outside LOAD, `core_data_in` SHALL be 32'h0.
REQ-012 WAIT_DONE SHALL sample `core_signals` every cycle and leave on the first cycle where `core_signals`==DONE_CODE.
REQ-013 On leaving WAIT_DONE, `core_data_out` in that same cycle SHALL be captured into `out_text[127:96]`.
- The following 3 cycles (UNLOAD) SHALL capture bits 95:64, 63:32 and 31:0.
- No cycles are skipped.
REQ-014 After the 4th capture, the block SHALL enter HOLD with `out_valid`=1.
- `out_valid` and `out_text` SHALL stay stable until `out_valid`&&`out_ready`.
- The block then returns to IDLE next cycle.
REQ-015 The accept-to-`out_valid` latency SHALL depend only on the core; the controller adds 0 cycles beyond the 4 capture cycles.
REQ-016 If `out_ready`=1 in the first HOLD cycle, `out_valid` SHALL be high for exactly 1 cycle.
REQ-017 `in_valid` SHALL be ignored in every state other than IDLE; no block is queued.
REQ-018 `core_signals` values other than DONE_CODE SHALL have no effect.

Reset
REQ-019 While `reset`=0, the block SHALL be in INIT_START with counter 0 and these outputs: `in_ready`=0, `out_valid`=0, `out_text`=0, `out_error`=0, `core_start`=1, `core_data_in`=0, `core_key_in`=0, `core_sel_enc_dec`=1.
REQ-020 Reset asserted mid-block SHALL discard the block immediately; after release, the full INIT sequence reruns.

Configuration
REQ-021 With `AES_SD_CTRL_TIMEOUT_EN` defined, WAIT_DONE SHALL count cycles.
- If TIMEOUT cycles pass without DONE_CODE, the block SHALL go to HOLD with `out_text`=0 and `out_error`=1.
- `out_error` SHALL clear when the result is consumed.
REQ-022 Without `AES_SD_CTRL_TIMEOUT_EN`, WAIT_DONE SHALL wait indefinitely, `out_error` SHALL be tied to 0, and no timeout counter SHALL exist.

Verification
REQ-023 Release reset -> `core_start`=1 for 2 cycles, then 0; `in_ready` rises exactly 86 cycles later.
REQ-024 Accept text 0x00112233_44556677_8899aabb_ccddeeff with `in_mode`=1:
- `core_start` is high for 2 cycles.
- `core_data_in` then carries 00112233, 44556677, 8899aabb and ccddeeff on consecutive cycles, then 0.
REQ-025 Core model raises `core_signals`=8'h10 with `core_data_out` words A, B, C, D on 4 cycles -> `out_text`={A,B,C,D}, with `out_valid` on the cycle after D.
REQ-026 Hold `out_ready`=0 for 10 cycles in HOLD -> `out_text` is stable and `in_ready` stays 0; a single-cycle `out_ready` then returns the block to IDLE.
REQ-027 Assert `reset` during LOAD word 2 -> all outputs take their reset values asynchronously, and the INIT sequence repeats.
REQ-028 With `AES_SD_CTRL_TIMEOUT_EN` and no done code -> after 255 WAIT_DONE cycles, `out_valid`=1, `out_error`=1 and `out_text`=0.
